// File: rtl/lif_pkg.sv
// Shared defaults and FSM encoding for the time-multiplexed LIF neuron scheduler.
package lif_pkg;

   localparam int LIF_N_NEURONS  = 4;
   localparam int LIF_WIDTH      = 8;
   localparam int LIF_THRESHOLD  = 128;
   localparam int LIF_LEAK_SHIFT = 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_COMMIT = 2'd2,
      ST_DONE   = 2'd3
   } lif_state_t;

   // Index width for a slot count; a single-slot build still needs one bit.
   function automatic int lif_addr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/lif_tdm_scheduler_if.sv
// Control, configuration and readback signals of the LIF scheduler.
interface lif_tdm_scheduler_if
   import lif_pkg::*;
#(
   parameter int N_NEURONS = LIF_N_NEURONS,
   parameter int WIDTH     = LIF_WIDTH
);
   localparam int AW = lif_addr_w(N_NEURONS);

   logic                 tick;
   logic [WIDTH-1:0]     ext_current;
   logic                 cfg_we;
   logic [AW-1:0]        cfg_addr;
   logic                 cfg_src;
   logic [AW-1:0]        rd_addr;
   logic [WIDTH-1:0]     rd_data;
   logic                 busy;
   logic                 done;
   logic [N_NEURONS-1:0] spikes;
   logic                 overrun;

   modport master (
      output tick, ext_current, cfg_we, cfg_addr, cfg_src, rd_addr,
      input  rd_data, busy, done, spikes, overrun
   );

   modport slave (
      input  tick, ext_current, cfg_we, cfg_addr, cfg_src, rd_addr,
      output rd_data, busy, done, spikes, overrun
   );

endinterface

// File: rtl/lif_tdm_scheduler_core.sv
// Leak / integrate / threshold / saturate datapath for one neuron update.
module lif_core
   import lif_pkg::*;
#(
   parameter int WIDTH      = LIF_WIDTH,
   parameter int THRESHOLD  = LIF_THRESHOLD,
   parameter int LEAK_SHIFT = LIF_LEAK_SHIFT
) (
   input  logic [WIDTH-1:0] state,
   input  logic [WIDTH-1:0] current,
   output logic             spike,
   output logic [WIDTH-1:0] next_state
);

   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] leaked;
   logic [WIDTH-1:0] sat;

   assign leaked = state >> LEAK_SHIFT;
   assign sum    = {1'b0, current} + {1'b0, leaked};
   // Threshold compared one bit wider so a THRESHOLD of 2^WIDTH never fires.
   assign spike  = ({1'b0, state} >= (WIDTH + 1)'(THRESHOLD));
   assign sat    = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];

   assign next_state = spike ? '0 : sat;

endmodule

// File: rtl/lif_tdm_scheduler.sv
// Sweeps N LIF neurons through one shared lif_core, one slot per FETCH/COMMIT pair.
//
// state  | meaning
// IDLE   | waiting for tick; cfg writes accepted
// FETCH  | register state[slot] and its input current
// COMMIT | write back updated state, record spike bit, advance slot
// DONE   | one-cycle done pulse, spikes already updated
module lif_tdm_scheduler
   import lif_pkg::*;
#(
   parameter int N_NEURONS  = LIF_N_NEURONS,
   parameter int WIDTH      = LIF_WIDTH,
   parameter int THRESHOLD  = LIF_THRESHOLD,
   parameter int LEAK_SHIFT = LIF_LEAK_SHIFT
) (
   input  logic                clk,
   input  logic                rst_n,
   lif_tdm_scheduler_if.slave  bus
);

   localparam int            AW        = lif_addr_w(N_NEURONS);
   localparam logic [AW-1:0] LAST_SLOT = AW'(N_NEURONS - 1);

   lif_state_t           state_q;
   logic [AW-1:0]        slot_q;
   logic [AW-1:0]        prev_slot;
   logic [WIDTH-1:0]     ext_reg;
   logic [WIDTH-1:0]     mem_q [N_NEURONS];
   logic [N_NEURONS-1:0] src_sel;
   logic [N_NEURONS-1:0] sweep_vec;
   logic [N_NEURONS-1:0] sweep_next;
   logic [N_NEURONS-1:0] spikes_q;
   logic                 overrun_q;
   logic [WIDTH-1:0]     cur_state_q;
   logic [WIDTH-1:0]     cur_current_q;
   logic [WIDTH-1:0]     slot_current;
   logic                 core_spike;
   logic [WIDTH-1:0]     core_next;

   // Chained slots read the neighbour as stored now, so slot 0 sees last sweep's final slot.
   assign prev_slot    = (slot_q == '0) ? LAST_SLOT : slot_q - AW'(1);
   assign slot_current = src_sel[slot_q] ? mem_q[prev_slot] : ext_reg;

   always_comb begin
      sweep_next         = sweep_vec;
      sweep_next[slot_q] = core_spike;
   end

   lif_core #(
      .WIDTH      (WIDTH),
      .THRESHOLD  (THRESHOLD),
      .LEAK_SHIFT (LEAK_SHIFT)
   ) u_core (
      .state      (cur_state_q),
      .current    (cur_current_q),
      .spike      (core_spike),
      .next_state (core_next)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         slot_q        <= '0;
         ext_reg       <= '0;
         src_sel       <= '0;
         sweep_vec     <= '0;
         spikes_q      <= '0;
         overrun_q     <= 1'b0;
         cur_state_q   <= '0;
         cur_current_q <= '0;
         for (int i = 0; i < N_NEURONS; i++) mem_q[i] <= '0;
      end else begin
         if (bus.tick && (state_q != ST_IDLE)) overrun_q <= 1'b1;
         case (state_q)
            ST_IDLE: begin
               if (bus.cfg_we) src_sel[bus.cfg_addr] <= bus.cfg_src;
               if (bus.tick) begin
                  ext_reg <= bus.ext_current;
                  slot_q  <= '0;
                  state_q <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               cur_state_q   <= mem_q[slot_q];
               cur_current_q <= slot_current;
               state_q       <= ST_COMMIT;
            end
            ST_COMMIT: begin
               mem_q[slot_q] <= core_next;
               sweep_vec     <= sweep_next;
               if (slot_q == LAST_SLOT) begin
                  spikes_q <= sweep_next;
                  state_q  <= ST_DONE;
               end else begin
                  slot_q  <= slot_q + AW'(1);
                  state_q <= ST_FETCH;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.rd_data = mem_q[bus.rd_addr];
   assign bus.busy    = (state_q != ST_IDLE);
   assign bus.done    = (state_q == ST_DONE);
   assign bus.spikes  = spikes_q;
   assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// Scoreboard bench for lif_tdm_scheduler: directed sweeps with hand-computed membrane/spike results.
module tb_lif_tdm_scheduler;
   import lif_pkg::*;

   typedef struct packed {
      logic [3:0]  spk;
      logic [31:0] st;   // slot3..slot0, 8 bits each
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   lif_tdm_scheduler_if #(.N_NEURONS(4), .WIDTH(8)) bus ();

   lif_tdm_scheduler #(
      .N_NEURONS (4),
      .WIDTH     (8),
      .THRESHOLD (128),
      .LEAK_SHIFT(1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   done_cnt = 0;
   int   chk_req  = 0;
   int   chk_seen = 0;

   function automatic logic [31:0] pk(input logic [7:0] s0, input logic [7:0] s1,
                                      input logic [7:0] s2, input logic [7:0] s3);
      return {s3, s2, s1, s0};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops one expectation per done pulse or per explicit state-check request.
   initial begin
      exp_t e;
      logic proc;
      bus.rd_addr = '0;
      forever begin
         @(negedge clk);
         proc = 1'b0;
         if (bus.done) begin
            done_cnt++;
            proc = 1'b1;
         end else if (chk_req != chk_seen) begin
            chk_seen++;
            proc = 1'b1;
         end
         if (proc) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_output: output seen with empty scoreboard at %0t", $time);
            end else begin
               e = sb.pop_front();
               check("spikes", 32'(bus.spikes), 32'(e.spk));
               for (int i = 0; i < 4; i++) begin
                  bus.rd_addr = 2'(i);
                  #1;
                  check($sformatf("state[%0d]", i), 32'(bus.rd_data), 32'(e.st[i*8 +: 8]));
               end
            end
         end
      end
   end

   task automatic wait_drain(input string name);
      int k;
      k = 0;
      while ((sb.size() != 0 || bus.busy) && k < 60) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (k >= 60) begin
         n_fail++;
         $display("FAIL %s_timeout: queue=%0d busy=%0b required empty/idle", name, sb.size(), bus.busy);
      end
      @(negedge clk);
   endtask

   task automatic push(input logic [31:0] st, input logic [3:0] spk);
      exp_t e;
      e.st  = st;
      e.spk = spk;
      sb.push_back(e);
   endtask

   task automatic sweep(input string name, input logic [7:0] ext, input logic cw,
                        input logic [1:0] ca, input logic cs,
                        input logic [31:0] st, input logic [3:0] spk);
      push(st, spk);
      @(negedge clk);
      bus.ext_current = ext;
      bus.tick        = 1'b1;
      bus.cfg_we      = cw;
      bus.cfg_addr    = ca;
      bus.cfg_src     = cs;
      @(negedge clk);
      bus.tick   = 1'b0;
      bus.cfg_we = 1'b0;
      wait_drain(name);
   endtask

   task automatic cfg_write(input logic [1:0] a, input logic s);
      @(negedge clk);
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = a;
      bus.cfg_src  = s;
      @(negedge clk);
      bus.cfg_we = 1'b0;
   endtask

   task automatic state_check(input string name);
      push(32'd0, 4'd0);
      chk_req++;
      wait_drain(name);
   endtask

   initial begin
      int d0;
      bus.tick        = 1'b0;
      bus.ext_current = '0;
      bus.cfg_we      = 1'b0;
      bus.cfg_addr    = '0;
      bus.cfg_src     = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_done", 32'(bus.done), 0);
      check("rst_overrun", 32'(bus.overrun), 0);
      check("rst_spikes", 32'(bus.spikes), 0);
      rst_n = 1'b1;
      state_check("rst_states");

      // External drive, leak accumulation then threshold crossing
      sweep("ext1", 8'd100, 1'b0, 2'd0, 1'b0, pk(100, 100, 100, 100), 4'b0000);
      sweep("ext2", 8'd100, 1'b0, 2'd0, 1'b0, pk(150, 150, 150, 150), 4'b0000);
      sweep("ext3", 8'd100, 1'b0, 2'd0, 1'b0, pk(0, 0, 0, 0), 4'b1111);

      // Saturation: 255 + 63 must clamp, 127 stays below threshold
      sweep("sat1", 8'd127, 1'b0, 2'd0, 1'b0, pk(127, 127, 127, 127), 4'b0000);
      sweep("sat2", 8'd255, 1'b0, 2'd0, 1'b0, pk(255, 255, 255, 255), 4'b0000);
      sweep("sat3", 8'd255, 1'b0, 2'd0, 1'b0, pk(0, 0, 0, 0), 4'b1111);

      // Chain 1110 with cycle-accurate busy/done timing
      cfg_write(2'd1, 1'b1);
      cfg_write(2'd2, 1'b1);
      cfg_write(2'd3, 1'b1);
      push(pk(100, 100, 100, 100), 4'b0000);
      @(negedge clk);
      bus.ext_current = 8'd100;
      bus.tick        = 1'b1;
      @(negedge clk);
      bus.tick = 1'b0;
      check("busy_t1", 32'(bus.busy), 1);
      check("done_t1", 32'(bus.done), 0);
      for (int k = 2; k <= 9; k++) begin
         @(negedge clk);
         check($sformatf("busy_t%0d", k), 32'(bus.busy), 1);
         check($sformatf("done_t%0d", k), 32'(bus.done), (k == 9) ? 1 : 0);
      end
      @(negedge clk);
      check("busy_t10", 32'(bus.busy), 0);
      check("done_t10", 32'(bus.done), 0);
      wait_drain("chain");

      // Overrun: second tick three edges later is ignored and sticky
      check("overrun_pre", 32'(bus.overrun), 0);
      d0 = done_cnt;
      push(pk(150, 200, 250, 255), 4'b0000);
      @(negedge clk);
      bus.ext_current = 8'd100;
      bus.tick        = 1'b1;
      @(negedge clk);
      bus.tick = 1'b0;
      @(negedge clk);
      bus.tick = 1'b1;
      @(negedge clk);
      bus.tick = 1'b0;
      check("overrun_set", 32'(bus.overrun), 1);
      wait_drain("overrun");
      check("overrun_one_done", 32'(done_cnt - d0), 1);
      check("overrun_sticky", 32'(bus.overrun), 1);
      sweep("chain_spike", 8'd100, 1'b0, 2'd0, 1'b0, pk(0, 0, 0, 0), 4'b1111);
      check("overrun_sticky2", 32'(bus.overrun), 1);

      // Reset mid-sweep at edge T+4
      d0 = done_cnt;
      @(negedge clk);
      bus.ext_current = 8'd50;
      bus.tick        = 1'b1;
      @(negedge clk);
      bus.tick = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_busy", 32'(bus.busy), 0);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      check("midrst_no_done", 32'(done_cnt - d0), 0);
      check("midrst_overrun", 32'(bus.overrun), 0);
      check("midrst_spikes", 32'(bus.spikes), 0);
      state_check("midrst_states");

      // cfg write while busy is dropped; src_sel also cleared by reset
      push(pk(20, 20, 20, 20), 4'b0000);
      @(negedge clk);
      bus.ext_current = 8'd20;
      bus.tick        = 1'b1;
      @(negedge clk);
      bus.tick     = 1'b0;
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 2'd2;
      bus.cfg_src  = 1'b1;
      @(negedge clk);
      bus.cfg_we = 1'b0;
      wait_drain("cfg_busy");
      sweep("cfg_busy2", 8'd20, 1'b0, 2'd0, 1'b0, pk(30, 30, 30, 30), 4'b0000);
      // Same write with tick in IDLE: slot 2 chains off slot 1 this sweep
      sweep("cfg_tick", 8'd60, 1'b1, 2'd2, 1'b1, pk(75, 75, 90, 75), 4'b0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lif_tdm_scheduler.md
LIF_TDM_SCHEDULER -- requirements
Module: lif_tdm_scheduler

Interface
REQ-001 SHALL have parameters: N_NEURONS, default 4, neuron slot count; WIDTH, default 8, membrane/current width; THRESHOLD, default 128, spike threshold; LEAK_SHIFT, default 1, leak right-shift amount.
REQ-002 SHALL have port clk, input, 1, single clock; all logic rising-edge.
REQ-003 SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-004 SHALL have port tick, input, 1, sweep request; sampled each edge.
REQ-005 SHALL have port ext_current, input, WIDTH, external stimulus current.
REQ-006 SHALL have port cfg_we, input, 1, source-select write strobe.
REQ-007 SHALL have port cfg_addr, input, log2(N_NEURONS), neuron index for cfg write.
REQ-008 SHALL have port cfg_src, input, 1, source select: 0 = external, 1 = previous neuron state.
REQ-009 SHALL have port rd_addr, input, log2(N_NEURONS), membrane readback index.
REQ-010 SHALL have port rd_data, output, WIDTH, combinational state[rd_addr].
REQ-011 SHALL have port busy, output, 1, high while a sweep is in progress.
REQ-012 SHALL have port done, output, 1, one-cycle sweep-complete pulse.
REQ-013 SHALL have port spikes, output, N_NEURONS, registered spike vector of the last completed sweep.
REQ-014 SHALL have port overrun, output, 1, sticky flag for a tick that arrives while not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, FETCH, COMMIT, DONE; slot counter 0..N_NEURONS-1.
REQ-016 IDLE with tick=1 SHALL latch ext_current into ext_reg, clear slot to 0, and go to FETCH.
REQ-017 FETCH SHALL register state[slot] and the slot current, then go to COMMIT.
REQ-018 Slot current SHALL be ext_reg if src_sel[slot]=0; otherwise state[(slot-1) mod N_NEURONS] as currently stored.
REQ-019 Consequence of REQ-018: a chain source for slot k>0 sees the value committed this sweep; slot 0 with src_sel=1 sees state[N-1] from the previous sweep.
REQ-020 COMMIT SHALL compute spike = (state >= THRESHOLD) and sum = current + (state >> LEAK_SHIFT), held WIDTH+1 bits wide.
REQ-021 COMMIT SHALL write state[slot] = 0 if spike, else min(sum, 2^WIDTH-1) (saturate, never wrap), and record spike in sweep_vec[slot].
REQ-022 After COMMIT, if slot < N_NEURONS-1, the FSM SHALL increment slot and go to FETCH; otherwise it SHALL go to DONE and load spikes from sweep_vec, including the last slot's bit, on the same edge.
REQ-023 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-024 busy SHALL be high in FETCH, COMMIT and DONE; a tick accepted at edge T gives busy in cycles T+1..T+2N+1 and done in cycle T+2N+1 (cycle T+9 at the default N_NEURONS).
REQ-025 A tick in any state other than IDLE SHALL be ignored and SHALL set overrun; overrun clears only on reset.
REQ-026 cfg_we in IDLE SHALL write src_sel[cfg_addr] = cfg_src at the edge; cfg_we while busy SHALL be ignored.
REQ-027 Simultaneous tick and cfg_we in IDLE: the cfg write SHALL take effect and the sweep SHALL use the new src_sel.
REQ-028 spikes SHALL hold its value between DONE cycles.

Reset
REQ-029 While rst_n=0 at an edge: FSM to IDLE; slot, ext_reg, all state[], src_sel, sweep_vec, spikes, done and overrun SHALL be 0, and busy SHALL be 0.
REQ-030 Reset asserted mid-sweep SHALL abort the sweep with no done pulse; the next tick after reset SHALL start from slot 0 with zeroed state.

Structure
REQ-031 A shared package lif_pkg SHALL hold the WIDTH, N_NEURONS, THRESHOLD and LEAK_SHIFT defaults and the FSM state enum.
REQ-032 The leak/integrate/threshold/saturate math SHALL live in one combinational sub-module, lif_core, instantiated once and shared across all slots.
REQ-033 Neuron state and src_sel SHALL be flop arrays inside lif_tdm_scheduler.

Verification
REQ-034 All src_sel=0, ext_current=100, three ticks -> all states 100, then 150, then 0; spikes=0000, 0000, 1111.
REQ-035 src_sel=4'b1110, ext_current=100, one tick -> every state=100 (the chain uses committed values); done in cycle T+9.
REQ-036 Saturation: src_sel=0, ext_current=127 tick, then ext_current=255 tick -> states 127, then 255 (no wrap, no spike); third tick -> spikes=1111, states 0.
REQ-037 Tick at T, second tick at T+3 -> second tick ignored, overrun=1 and stays 1; exactly one done pulse.
REQ-038 rst_n=0 at T+4 of a sweep -> busy=0 next cycle, no done, all states 0, spikes=0, overrun=0.
REQ-039 cfg_we with cfg_addr=2, cfg_src=1 during busy -> src_sel unchanged; the same write in IDLE together with a tick -> neuron 2 sources state[1] in that sweep.
